sprite_bitmap_loader: RTL and testbench

SPRITE_BITMAP_LOADER -- requirements
Module: sprite_bitmap_loader

---
 rtl/sprite_bitmap_loader.sv | 129 ++++++++++++
 tb/tb_sprite_bitmap_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_bitmap_loader.sv
`default_nettype none
// ============================================================================
// Module   : sprite_bitmap_loader
// Brief    : Double-buffered sprite row store; fills the back bank, flips on vsync.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_bitmap_loader #(
  parameter int ROWS  = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_sof,
  output logic             wr_ready,
  input  logic             vsync,
  input  logic [3:0]       rd_yofs,
  output logic [WIDTH-1:0] rd_bits,
  output logic             swap_done,
  output logic             err
);

  localparam int              c_RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(ROWS - 1);
  localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_RW-1:0] r_row, w_row_nxt;
  logic            r_disp_sel, w_disp_sel_nxt;
  logic            r_vsync_q;
  logic            r_swap_done, w_swap_nxt;
  logic            r_err, w_err_nxt;
  logic            w_edge, w_xfer, w_we;
  logic [c_RW-1:0] w_waddr;
  logic [c_RW-1:0] w_rd_idx;

  // Banks power up cleared; reset intentionally leaves them alone.
  logic [WIDTH-1:0] r_bank [2][ROWS] = '{default: '{default: '0}};

  assign wr_ready  = (r_state != ST_PENDING);
  assign w_xfer    = wr_valid & wr_ready;
  assign w_edge    = vsync & ~r_vsync_q;
  assign swap_done = r_swap_done;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_disp_sel  <= 1'b0;
      r_swap_done <= 1'b0;
      r_err       <= 1'b0;
      r_vsync_q   <= vsync;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_disp_sel  <= w_disp_sel_nxt;
      r_swap_done <= w_swap_nxt;
      r_err       <= w_err_nxt;
      r_vsync_q   <= vsync;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_disp_sel_nxt = r_disp_sel;
    w_swap_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_we           = 1'b0;
    w_waddr        = r_row;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (wr_sof) begin
            w_we        = 1'b1;
            w_waddr     = '0;
            w_row_nxt   = c_ROW_ONE;
            w_state_nxt = ST_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          w_we = 1'b1;
          if (wr_sof) begin
            // Restart the sprite from row 0 but flag the broken framing.
            w_waddr   = '0;
            w_row_nxt = c_ROW_ONE;
            w_err_nxt = 1'b1;
          end else if (r_row == c_LAST_ROW) begin
            w_row_nxt   = '0;
            w_state_nxt = ST_PENDING;
          end else begin
            w_row_nxt = r_row + c_ROW_ONE;
          end
        end
      end
      ST_PENDING: begin
        if (w_edge) begin
          w_disp_sel_nxt = ~r_disp_sel;
          w_swap_nxt     = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_bank[~r_disp_sel][w_waddr] <= wr_data;
    end
  end

  assign w_rd_idx = c_RW'(rd_yofs);
  assign rd_bits  = (int'(rd_yofs) < ROWS) ? r_bank[r_disp_sel][w_rd_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_bitmap_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_bitmap_loader
// Brief    : Scoreboard bench; loaded sprites are queued and checked after each flip.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_bitmap_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_sof = 1'b0;
  logic       wr_ready;
  logic       vsync = 1'b0;
  logic [3:0] rd_yofs = '0;
  logic [7:0] rd_bits;
  logic       swap_done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb_q [$];
  logic [7:0] disp_model [16];

  sprite_bitmap_loader #(.ROWS(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_sof(wr_sof), .wr_ready(wr_ready), .vsync(vsync), .rd_yofs(rd_yofs),
    .rd_bits(rd_bits), .swap_done(swap_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int s, input int r);
    logic [7:0] first3 [3];
    first3 = '{8'h00, 8'h0C, 8'hCC};
    if (s == 0 && r < 3) return first3[r];
    return 8'(s * 16 + r) ^ 8'hA5;
  endfunction

  // Drives nrows back-to-back transfers; optionally raises vsync on the last one.
  task automatic load_sprite(input int s, input int nrows, input bit vs_last, input bit push);
    for (int r = 0; r < nrows; r++) begin
      wr_valid = 1'b1;
      wr_sof   = (r == 0);
      wr_data  = pat(s, r);
      if (vs_last && r == nrows - 1) vsync = 1'b1;
      if (push) sb_q.push_back(pat(s, r));
      tick();
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic sweep_model(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_yofs = 4'(r);
      #1;
      check_eq(tag, {24'b0, rd_bits}, {24'b0, disp_model[r]});
    end
  endtask

  task automatic verify_display(input string tag);
    check_eq({tag, "_sb_depth"}, (sb_q.size() >= 16) ? 32'd1 : 32'd0, 32'd1);
    for (int r = 0; r < 16; r++) begin
      if (sb_q.size() > 0) disp_model[r] = sb_q.pop_front();
    end
    sweep_model(tag);
  endtask

  task automatic vsync_swap(input string tag);
    vsync = 1'b1;
    tick();
    check_eq({tag, "_swap_hi"}, {31'b0, swap_done}, 32'd1);
    vsync = 1'b0;
    tick();
    check_eq({tag, "_swap_lo"}, {31'b0, swap_done}, 32'd0);
    check_eq({tag, "_ready"}, {31'b0, wr_ready}, 32'd1);
    verify_display(tag);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) disp_model[r] = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Power-up state
    check_eq("pu_ready", {31'b0, wr_ready}, 32'd1);
    check_eq("pu_err", {31'b0, err}, 32'd0);
    check_eq("pu_swap", {31'b0, swap_done}, 32'd0);
    sweep_model("pu_rd");

    // Basic load and flip
    load_sprite(0, 16, 1'b0, 1'b1);
    check_eq("a_ready_pend", {31'b0, wr_ready}, 32'd1 - 32'd1);
    vsync_swap("a");
    rd_yofs = 4'd2;
    #1;
    check_eq("a_row2", {24'b0, rd_bits}, 32'h0000_00CC);

    // Idle vsync edge does nothing
    vsync = 1'b1;
    tick();
    check_eq("idle_vs_noswap", {31'b0, swap_done}, 32'd0);
    vsync = 1'b0;
    tick();
    sweep_model("idle_vs_rd");

    // Back-pressure while pending
    load_sprite(1, 16, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_sof   = 1'b1;
      wr_data  = 8'hFF;
      #1;
      check_eq("b_stall_ready", {31'b0, wr_ready}, 32'd0);
      tick();
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    check_eq("b_swap_idle", {31'b0, swap_done}, 32'd0);
    sweep_model("b_old_bank");
    check_eq("b_err", {31'b0, err}, 32'd0);
    vsync_swap("b");

    // Stray byte in IDLE sets sticky err
    wr_valid = 1'b1;
    wr_sof   = 1'b0;
    wr_data  = 8'h77;
    tick();
    wr_valid = 1'b0;
    check_eq("c_err_set", {31'b0, err}, 32'd1);
    check_eq("c_idle_ready", {31'b0, wr_ready}, 32'd1);
    sweep_model("c_no_write");
    load_sprite(2, 16, 1'b0, 1'b1);
    check_eq("c_ready_pend", {31'b0, wr_ready}, 32'd0);
    check_eq("c_err_hold", {31'b0, err}, 32'd1);
    vsync_swap("c");
    check_eq("c_err_after", {31'b0, err}, 32'd1);

    // Reset mid-load: display returns to bank 0, which holds B with rows 0..6 overwritten
    load_sprite(4, 7, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("r_ready", {31'b0, wr_ready}, 32'd1);
    check_eq("r_err", {31'b0, err}, 32'd0);
    check_eq("r_swap", {31'b0, swap_done}, 32'd0);
    for (int r = 0; r < 16; r++) disp_model[r] = (r < 7) ? pat(4, r) : pat(1, r);
    sweep_model("r_bank0");
    load_sprite(5, 16, 1'b0, 1'b1);
    check_eq("f_ready_pend", {31'b0, wr_ready}, 32'd0);
    vsync_swap("f");

    // vsync edge coincident with the final row must not flip
    load_sprite(6, 16, 1'b1, 1'b1);
    check_eq("d_no_swap", {31'b0, swap_done}, 32'd0);
    check_eq("d_ready_pend", {31'b0, wr_ready}, 32'd0);
    vsync = 1'b0;
    tick();
    check_eq("d_no_swap2", {31'b0, swap_done}, 32'd0);
    sweep_model("d_old_bank");
    vsync_swap("d");

    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
